// File: rtl/link_mm_req_sequencer.sv
// link_mm_req_sequencer
// Turns host register requests into single-cycle strobes towards the link
// address decoder. One transaction is in flight at a time. Writes are posted.
// Reads wait for decoder data, or time out and return an error pattern.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Request side is iREQ_V/oREQ_RDY. Response side is
// oRSP_V/iRSP_RDY. Ready never depends combinationally on valid.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   iREQ_V/oREQ_RDY   host request handshake
//   iREQ_WR           1 = write, 0 = read
//   iREQ_ADDR         request address
//   iREQ_WDATA        request write data
//   oRSP_V/iRSP_RDY   read response handshake
//   oRSP_DATA         read data, or the DEAD pattern on timeout
//   oRSP_ERR          1 = read timed out
//   oMM_ADDR          decoder address (registered, held between requests)
//   oMM_WR_DATA       decoder write data (registered, held between requests)
//   oMM_WR_EN         single-cycle write strobe
//   oMM_RD_EN         single-cycle read strobe
//   iMM_RD_DATA(_V)   decoder read data and valid, honoured only while waiting
//   oBUSY             high whenever the FSM is not idle
//   oTIMEOUT_CNT      saturating count of read timeouts
//   dbg_state         FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP
module link_mm_req_sequencer #(
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iREQ_V,
   output logic              oREQ_RDY,
   input  logic              iREQ_WR,
   input  logic [ADDR_W-1:0] iREQ_ADDR,
   input  logic [DATA_W-1:0] iREQ_WDATA,
   output logic              oRSP_V,
   input  logic              iRSP_RDY,
   output logic [DATA_W-1:0] oRSP_DATA,
   output logic              oRSP_ERR,
   output logic [ADDR_W-1:0] oMM_ADDR,
   output logic              oMM_WR_EN,
   output logic              oMM_RD_EN,
   output logic [DATA_W-1:0] oMM_WR_DATA,
   input  logic [DATA_W-1:0] iMM_RD_DATA,
   input  logic              iMM_RD_DATA_V,
   output logic              oBUSY,
   output logic [15:0]       oTIMEOUT_CNT,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [63:0]       DEAD64    = 64'hDEAD_DEAD_DEAD_DEAD;
   localparam logic [DATA_W-1:0] DEAD_PAT  = DATA_W'(DEAD64);
   localparam logic [15:0]       TIMER_MAX = 16'(TIMEOUT);

   state_t            state_q, state_d;
   logic              req_rdy_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [15:0]       timer_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;
   logic [15:0]       to_cnt_q;

   logic              accept;
   logic              rd_hit;
   logic              rd_timeout;

   // Next-state logic. Data valid is checked before the timer, so data that
   // arrives on the timeout cycle still wins.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      rd_hit     = 1'b0;
      rd_timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (iREQ_V && req_rdy_q) begin
               accept  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = wr_q ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (iMM_RD_DATA_V) begin
               rd_hit  = 1'b1;
               state_d = S_RESP;
            end else if (timer_q == TIMER_MAX) begin
               rd_timeout = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (iRSP_RDY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_rdy_q  <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         timer_q    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         to_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         // Ready is registered from the next state. It stays low through
         // reset and rises on the first clock after release.
         req_rdy_q <= (state_d == S_IDLE);
         if (accept) begin
            wr_q    <= iREQ_WR;
            addr_q  <= iREQ_ADDR;
            wdata_q <= iREQ_WDATA;
         end
         if (state_q == S_ISSUE) begin
            timer_q <= '0;
         end else if (state_q == S_WAIT) begin
            timer_q <= timer_q + 16'd1;
         end
         if (rd_hit) begin
            rsp_data_q <= iMM_RD_DATA;
            rsp_err_q  <= 1'b0;
         end else if (rd_timeout) begin
            rsp_data_q <= DEAD_PAT;
            rsp_err_q  <= 1'b1;
            if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
         end
      end
   end

   assign oREQ_RDY     = req_rdy_q;
   assign oMM_ADDR     = addr_q;
   assign oMM_WR_DATA  = wdata_q;
   assign oMM_WR_EN    = (state_q == S_ISSUE) &&  wr_q;
   assign oMM_RD_EN    = (state_q == S_ISSUE) && !wr_q;
   assign oRSP_V       = (state_q == S_RESP);
   assign oRSP_DATA    = rsp_data_q;
   assign oRSP_ERR     = rsp_err_q;
   assign oBUSY        = (state_q != S_IDLE);
   assign oTIMEOUT_CNT = to_cnt_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_link_mm_req_sequencer.sv
// Directed bench for link_mm_req_sequencer. Inputs are driven and outputs
// are sampled on the falling clock edge. Each expected read response is
// queued when its request is issued, and checked when oRSP_V is seen.
module tb_link_mm_req_sequencer;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_v = 1'b0;
   logic        req_rdy;
   logic        req_wr = 1'b0;
   logic [16:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_v;
   logic        rsp_rdy = 1'b0;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic [16:0] mm_addr;
   logic        mm_wr_en;
   logic        mm_rd_en;
   logic [63:0] mm_wr_data;
   logic [63:0] mm_rd_data = '0;
   logic        mm_rd_data_v = 1'b0;
   logic        busy;
   logic [15:0] tcnt;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [64:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   link_mm_req_sequencer #(.ADDR_W(17), .DATA_W(64), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .iREQ_V(req_v), .oREQ_RDY(req_rdy), .iREQ_WR(req_wr),
      .iREQ_ADDR(req_addr), .iREQ_WDATA(req_wdata),
      .oRSP_V(rsp_v), .iRSP_RDY(rsp_rdy), .oRSP_DATA(rsp_data), .oRSP_ERR(rsp_err),
      .oMM_ADDR(mm_addr), .oMM_WR_EN(mm_wr_en), .oMM_RD_EN(mm_rd_en),
      .oMM_WR_DATA(mm_wr_data), .iMM_RD_DATA(mm_rd_data), .iMM_RD_DATA_V(mm_rd_data_v),
      .oBUSY(busy), .oTIMEOUT_CNT(tcnt), .dbg_state(dbg_state)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rdy"},      64'(req_rdy),    64'd0);
      check({tag, "_busy"},     64'(busy),       64'd0);
      check({tag, "_rsp_v"},    64'(rsp_v),      64'd0);
      check({tag, "_wr_en"},    64'(mm_wr_en),   64'd0);
      check({tag, "_rd_en"},    64'(mm_rd_en),   64'd0);
      check({tag, "_rsp_data"}, rsp_data,        64'd0);
      check({tag, "_rsp_err"},  64'(rsp_err),    64'd0);
      check({tag, "_mm_addr"},  64'(mm_addr),    64'd0);
      check({tag, "_wr_data"},  mm_wr_data,      64'd0);
      check({tag, "_tcnt"},     64'(tcnt),       64'd0);
      check({tag, "_state"},    64'(dbg_state),  64'd0);
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge with the sequencer idle.
   task automatic do_write(input logic [16:0] addr, input logic [63:0] data);
      check("wr_pre_rdy", 64'(req_rdy), 64'd1);
      req_v = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data;
      @(negedge clk);
      req_v = 1'b0; req_addr = 17'($urandom); req_wdata = {$urandom, $urandom};
      check("wr_strobe",  64'(mm_wr_en), 64'd1);
      check("wr_no_rd",   64'(mm_rd_en), 64'd0);
      check("wr_addr",    64'(mm_addr),  64'(addr));
      check("wr_data",    mm_wr_data,    data);
      check("wr_rdy_low", 64'(req_rdy),  64'd0);
      @(negedge clk);
      check("wr_strobe_end", 64'(mm_wr_en), 64'd0);
      check("wr_no_rsp",     64'(rsp_v),    64'd0);
      check("wr_rdy_back",   64'(req_rdy),  64'd1);
      check("wr_addr_hold",  64'(mm_addr),  64'(addr));
   endtask

   // Issues a read. If give is set, data valid is driven 'delay' cycles after
   // the read strobe. Returns at the falling edge where oRSP_V is expected.
   task automatic do_read(input logic [16:0] addr, input int delay, input bit give,
                          input logic [63:0] data, input logic [64:0] exp);
      exp_q.push_back(exp);
      check("rd_pre_rdy", 64'(req_rdy), 64'd1);
      req_v = 1'b1; req_wr = 1'b0; req_addr = addr;
      @(negedge clk);
      req_v = 1'b0;
      check("rd_strobe", 64'(mm_rd_en), 64'd1);
      check("rd_no_wr",  64'(mm_wr_en), 64'd0);
      check("rd_addr",   64'(mm_addr),  64'(addr));
      for (int i = 1; i <= delay; i++) begin
         @(negedge clk);
         mm_rd_data_v = 1'b0;
         check("rd_wait_no_rsp", 64'(rsp_v),    64'd0);
         check("rd_wait_no_stb", 64'(mm_rd_en), 64'd0);
         if (give && i == delay) begin
            mm_rd_data_v = 1'b1;
            mm_rd_data   = data;
         end
      end
      @(negedge clk);
      mm_rd_data_v = 1'b0;
      mm_rd_data   = {$urandom, $urandom};
      check("rd_rsp_v", 64'(rsp_v), 64'd1);
   endtask

   // Called with oRSP_V high. Holds iRSP_RDY low for 'hold' cycles, with an
   // optional stray data pulse during the hold, then accepts the response.
   task automatic collect_rsp(input int hold, input bit stray);
      logic [64:0] exp;
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("rsp_data", rsp_data, exp[63:0]);
      check("rsp_err",  64'(rsp_err), 64'(exp[64]));
      check("rsp_rdy_low", 64'(req_rdy), 64'd0);
      for (int i = 0; i < hold; i++) begin
         if (stray && i == 0) begin
            mm_rd_data_v = 1'b1;
            mm_rd_data   = {$urandom, $urandom};
         end
         @(negedge clk);
         mm_rd_data_v = 1'b0;
         check("hold_rsp_v",    64'(rsp_v),   64'd1);
         check("hold_rsp_data", rsp_data,     exp[63:0]);
         check("hold_rsp_err",  64'(rsp_err), 64'(exp[64]));
         check("hold_rdy_low",  64'(req_rdy), 64'd0);
      end
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      check("post_rsp_v",    64'(rsp_v),   64'd0);
      check("post_rsp_rdy",  64'(req_rdy), 64'd1);
      check("post_rsp_busy", 64'(busy),    64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [63:0] d;
      logic [63:0] dead;
      dead = 64'hDEAD_DEAD_DEAD_DEAD;

      // Reset values while held in reset.
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("rdy_after_reset", 64'(req_rdy), 64'd1);

      // Posted write.
      do_write(17'h00010, 64'h1122_3344_5566_7788);

      // Read with data valid three cycles after the strobe.
      do_read(17'h04000, 3, 1'b1, 64'hCAFE, {1'b0, 64'hCAFE});
      collect_rsp(0, 1'b0);

      // Read with no data times out. Stray data during RESP is ignored.
      do_read(17'h00123, TO + 1, 1'b0, 64'd0, {1'b1, dead});
      check("to_cnt_1", 64'(tcnt), 64'd1);
      collect_rsp(2, 1'b1);

      // Late data while idle is ignored.
      mm_rd_data_v = 1'b1; mm_rd_data = 64'h5555_AAAA_5555_AAAA;
      @(negedge clk);
      mm_rd_data_v = 1'b0;
      check("late_busy",     64'(busy),    64'd0);
      check("late_rsp_v",    64'(rsp_v),   64'd0);
      check("late_rsp_data", rsp_data,     dead);
      check("late_rsp_err",  64'(rsp_err), 64'd1);
      check("late_tcnt",     64'(tcnt),    64'd1);

      // Response held for ten cycles.
      d = {$urandom, $urandom};
      do_read(17'h1ABCD, 2, 1'b1, d, {1'b0, d});
      collect_rsp(10, 1'b0);

      // Data on the exact timeout cycle wins.
      d = {$urandom, $urandom};
      do_read(17'(($urandom_range(0, 131071))), TO + 1, 1'b1, d, {1'b0, d});
      check("exact_to_tcnt", 64'(tcnt), 64'd1);
      collect_rsp(0, 1'b0);

      // Reset during WAIT abandons the read.
      do_write(17'h0BEEF, {$urandom, $urandom} | 64'd1);
      req_v = 1'b1; req_wr = 1'b0; req_addr = 17'h00777;
      @(negedge clk);
      req_v = 1'b0;
      check("rst_rd_strobe", 64'(mm_rd_en), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      mm_rd_data_v = 1'b1;
      @(negedge clk);
      check_reset_values("mid_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_rsp_v", 64'(rsp_v),    64'd0);
      check("rel_rd_en", 64'(mm_rd_en), 64'd0);
      check("rel_busy",  64'(busy),     64'd0);
      check("rel_rdy",   64'(req_rdy),  64'd1);
      mm_rd_data_v = 1'b0;
      @(negedge clk);
      check("rel_rsp_v2", 64'(rsp_v), 64'd0);

      // Back-to-back reads after release.
      d = {$urandom, $urandom};
      do_read(17'h00040, 1, 1'b1, d, {1'b0, d});
      collect_rsp(0, 1'b0);
      d = {$urandom, $urandom};
      do_read(17'h00048, 4, 1'b1, d, {1'b0, d});
      collect_rsp(0, 1'b0);
      check("final_tcnt", 64'(tcnt), 64'd0);
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/link_mm_req_sequencer.md
LINK_MM_REQ_SEQUENCER -- requirements
Module: link_mm_req_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, 17, register-space address width.
REQ-002 SHALL have parameter DATA_W, 64, register data width.
REQ-003 SHALL have parameter TIMEOUT, 255, maximum wait cycles for read data (legal range 1..65535).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iREQ_V  input  1  host request valid.
REQ-007 SHALL have port oREQ_RDY  output  1  request accepted when high with iREQ_V.
REQ-008 SHALL have port iREQ_WR  input  1  1 = write, 0 = read.
REQ-009 SHALL have port iREQ_ADDR  input  ADDR_W  request address.
REQ-010 SHALL have port iREQ_WDATA  input  DATA_W  write data.
REQ-011 SHALL have port oRSP_V  output  1  read response valid.
REQ-012 SHALL have port iRSP_RDY  input  1  host accepts response.
REQ-013 SHALL have port oRSP_DATA  output  DATA_W  read data.
REQ-014 SHALL have port oRSP_ERR  output  1  1 = read timed out.
REQ-015 SHALL have port oMM_ADDR  output  ADDR_W  address to link address decoder.
REQ-016 SHALL have port oMM_WR_EN  output  1  single-cycle write strobe.
REQ-017 SHALL have port oMM_RD_EN  output  1  single-cycle read strobe.
REQ-018 SHALL have port oMM_WR_DATA  output  DATA_W  write data to decoder.
REQ-019 SHALL have port iMM_RD_DATA  input  DATA_W  read data from decoder.
REQ-020 SHALL have port iMM_RD_DATA_V  input  1  read data valid from decoder.
REQ-021 SHALL have port oBUSY  output  1  high whenever state is not IDLE.
REQ-022 SHALL have port oTIMEOUT_CNT  output  16  saturating count of read timeouts.

Function
REQ-023 SHALL implement states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-024 oREQ_RDY SHALL be high only in IDLE, driven from registered state, no combinational path from iREQ_V.
REQ-025 On iREQ_V & oREQ_RDY SHALL latch iREQ_WR/ADDR/WDATA and move to ISSUE.
REQ-026 ISSUE SHALL last exactly one cycle: oMM_WR_EN (write) or oMM_RD_EN (read) high, never both; oMM_ADDR/oMM_WR_DATA carry latched values that cycle.
REQ-027 Writes SHALL be posted: ISSUE -> IDLE, no response; next request accepted in the following cycle.
REQ-028 Reads: ISSUE -> WAIT, wait timer cleared to 0, incremented each WAIT cycle.
REQ-029 In WAIT, iMM_RD_DATA_V high SHALL capture iMM_RD_DATA into oRSP_DATA, clear oRSP_ERR, go to RESP.
REQ-030 In WAIT, timer == TIMEOUT with iMM_RD_DATA_V low SHALL set oRSP_DATA = 64'hDEAD_DEAD_DEAD_DEAD, oRSP_ERR = 1, increment oTIMEOUT_CNT (saturate at 16'hFFFF), go to RESP.
REQ-031 Simultaneous data valid and timer == TIMEOUT: data valid wins, no timeout counted.
REQ-032 oRSP_V SHALL be high throughout RESP; oRSP_DATA/oRSP_ERR stable until iRSP_RDY sampled high, then -> IDLE.
REQ-033 iMM_RD_DATA_V outside WAIT (late or stray data) SHALL be ignored with no state or output change.
REQ-034 oMM_ADDR and oMM_WR_DATA SHALL be registered and hold their last values outside ISSUE.
REQ-035 Read latency: oRSP_V SHALL rise the cycle after iMM_RD_DATA_V is sampled in WAIT.

Reset
REQ-036 On rst_n low: state IDLE, oREQ_RDY 0 during reset then 1 first cycle after, oRSP_V/oMM_WR_EN/oMM_RD_EN/oBUSY 0, oRSP_DATA/oMM_ADDR/oMM_WR_DATA/oTIMEOUT_CNT/timer 0, oRSP_ERR 0.
REQ-037 Reset asserted mid-transaction SHALL abandon it; no strobe or response issued after release.

Verification
REQ-038 Write 0x00010 data 0x1122334455667788 -> one-cycle oMM_WR_EN with that addr/data, no oRSP_V, oREQ_RDY high 2 cycles after acceptance.
REQ-039 Read 0x04000, drive iMM_RD_DATA_V 3 cycles after oMM_RD_EN with 0xCAFE -> oRSP_V next cycle, oRSP_DATA 0xCAFE, oRSP_ERR 0.
REQ-040 Read with no data, TIMEOUT 8 -> oRSP_ERR 1, oRSP_DATA 0xDEADDEADDEADDEAD, oTIMEOUT_CNT 1; late data then ignored.
REQ-041 Hold iRSP_RDY low 10 cycles in RESP -> oRSP_V and data stable, oREQ_RDY low; release -> IDLE next cycle.
REQ-042 Data valid on the exact timeout cycle -> good data returned, oTIMEOUT_CNT unchanged.
REQ-043 Assert rst_n low during WAIT -> all outputs at reset values; back-to-back reads after release complete normally.
